// File: rtl/snake_engine.sv
// Snake body datapath: head-first segment shift array with per-move wall, food and self-collision checks.
// Build option SNAKE_WRAP_EN: playfield edges wrap around and wall_collision never fires.
module snake_engine #(
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 24,
  parameter int unsigned X_W      = 5,
  parameter int unsigned Y_W      = 5,
  parameter int unsigned MAX_LEN  = 64,
  parameter int unsigned LEN_W    = 7,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       game_state,
  input  logic             move_enable,
  input  logic [1:0]       dir_in,
  input  logic             dir_valid,
  input  logic [X_W-1:0]   food_x,
  input  logic [Y_W-1:0]   food_y,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [X_W-1:0]   rd_x,
  output logic [Y_W-1:0]   rd_y,
  output logic             rd_valid,
  output logic [X_W-1:0]   head_x,
  output logic [Y_W-1:0]   head_y,
  output logic [LEN_W-1:0] length,
  output logic             busy,
  output logic             wall_collision,
  output logic             self_collision,
  output logic             food_eaten
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ST_READY  = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  localparam logic [1:0] GS_IDLE    = 2'b00;
  localparam logic [1:0] GS_PLAYING = 2'b01;

  localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
  localparam logic [Y_W-1:0]   HOME_Y   = Y_W'(GRID_H / 2);
  localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  function automatic logic [X_W-1:0] init_x(input int unsigned i);
    return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : '0;
  endfunction

  function automatic logic [Y_W-1:0] init_y(input int unsigned i);
    return (i < INIT_LEN) ? HOME_Y : '0;
  endfunction

  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];

  logic [1:0]       state_q, state_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       pend_dir_q, pend_dir_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [X_W-1:0]   nx_q, nx_d;
  logic [Y_W-1:0]   ny_q, ny_d;
  logic             grow_q, grow_d;
  logic             hit_q, hit_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] n_q, n_d;
  logic             busy_q, busy_d;
  logic             wall_q, wall_d;
  logic             self_q, self_d;
  logic             food_q, food_d;

  logic             init_c, shift_c, playing_c;
  logic [1:0]       eff_dir_c;
  logic [X_W-1:0]   nx_c;
  logic [Y_W-1:0]   ny_c;
  logic             edge_c, wall_c, grow_c, match_c;

  assign playing_c = (game_state == GS_PLAYING);

  // Direction seen by a move this cycle: a same-cycle non-reversing request overrides pending.
  always_comb begin
    eff_dir_c = pend_dir_q;
    if (dir_valid && (dir_in != (cur_dir_q ^ 2'b10))) begin
      eff_dir_c = dir_in;
    end
  end

  // Candidate head; at an edge the coordinate is the wrapped one, used only when wrapping.
  always_comb begin
    nx_c   = seg_x_q[0];
    ny_c   = seg_y_q[0];
    edge_c = 1'b0;
    case (eff_dir_c)
      DIR_UP: begin
        edge_c = (seg_y_q[0] == '0);
        ny_c   = edge_c ? Y_MAX : seg_y_q[0] - 1'b1;
      end
      DIR_RIGHT: begin
        edge_c = (seg_x_q[0] == X_MAX);
        nx_c   = edge_c ? '0 : seg_x_q[0] + 1'b1;
      end
      DIR_DOWN: begin
        edge_c = (seg_y_q[0] == Y_MAX);
        ny_c   = edge_c ? '0 : seg_y_q[0] + 1'b1;
      end
      default: begin
        edge_c = (seg_x_q[0] == '0);
        nx_c   = edge_c ? X_MAX : seg_x_q[0] - 1'b1;
      end
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_c = 1'b0;
`else
  assign wall_c = edge_c;
`endif

  assign grow_c  = (nx_c == food_x) && (ny_c == food_y);
  assign match_c = (seg_x_q[IDX_W'(k_q)] == nx_q) && (seg_y_q[IDX_W'(k_q)] == ny_q);

  always_comb begin
    state_d    = state_q;
    cur_dir_d  = cur_dir_q;
    pend_dir_d = eff_dir_c;
    len_d      = len_q;
    nx_d       = nx_q;
    ny_d       = ny_q;
    grow_d     = grow_q;
    hit_d      = hit_q;
    k_d        = k_q;
    n_d        = n_q;
    wall_d     = 1'b0;
    self_d     = 1'b0;
    food_d     = 1'b0;
    init_c     = 1'b0;
    shift_c    = 1'b0;

    if (game_state == GS_IDLE) begin
      state_d    = ST_READY;
      cur_dir_d  = DIR_RIGHT;
      pend_dir_d = DIR_RIGHT;
      len_d      = LEN_INIT;
      hit_d      = 1'b0;
      k_d        = '0;
      init_c     = 1'b1;
    end else begin
      case (state_q)
        ST_READY: begin
          if (move_enable && playing_c) begin
            cur_dir_d = eff_dir_c;
            if (wall_c) begin
              wall_d = 1'b1;
            end else begin
              nx_d    = nx_c;
              ny_d    = ny_c;
              grow_d  = grow_c;
              hit_d   = 1'b0;
              k_d     = '0;
              // The tail cell vacates this move unless the snake grows.
              n_d     = grow_c ? len_q : len_q - 1'b1;
              state_d = ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (!playing_c) begin
            state_d = ST_READY;
          end else begin
            if (match_c) begin
              hit_d = 1'b1;
            end
            if (k_q == n_q - 1'b1) begin
              state_d = ST_COMMIT;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          state_d = ST_READY;
          if (playing_c) begin
            if (hit_q) begin
              self_d = 1'b1;
            end else begin
              shift_c = 1'b1;
              food_d  = grow_q;
              if (grow_q && (len_q != LEN_MAX)) begin
                len_d = len_q + 1'b1;
              end
            end
          end
        end
        default: state_d = ST_READY;
      endcase
    end

    busy_d = (state_d != ST_READY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_READY;
      cur_dir_q  <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      len_q      <= LEN_INIT;
      nx_q       <= '0;
      ny_q       <= '0;
      grow_q     <= 1'b0;
      hit_q      <= 1'b0;
      k_q        <= '0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      wall_q     <= 1'b0;
      self_q     <= 1'b0;
      food_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_dir_q  <= cur_dir_d;
      pend_dir_q <= pend_dir_d;
      len_q      <= len_d;
      nx_q       <= nx_d;
      ny_q       <= ny_d;
      grow_q     <= grow_d;
      hit_q      <= hit_d;
      k_q        <= k_d;
      n_q        <= n_d;
      busy_q     <= busy_d;
      wall_q     <= wall_d;
      self_q     <= self_d;
      food_q     <= food_d;
    end
  end

  // Segment array: initialise, or shift toward the tail with the new head at index 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[IDX_W'(i)] <= init_x(i);
        seg_y_q[IDX_W'(i)] <= init_y(i);
      end
    end else if (init_c) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        seg_x_q[IDX_W'(i)] <= init_x(i);
        seg_y_q[IDX_W'(i)] <= init_y(i);
      end
    end else if (shift_c) begin
      for (int unsigned i = MAX_LEN - 1; i > 0; i--) begin
        seg_x_q[IDX_W'(i)] <= seg_x_q[IDX_W'(i - 1)];
        seg_y_q[IDX_W'(i)] <= seg_y_q[IDX_W'(i - 1)];
      end
      seg_x_q[0] <= nx_q;
      seg_y_q[0] <= ny_q;
    end
  end

  always_comb begin
    rd_x = '0;
    rd_y = '0;
    if (rd_idx < LEN_MAX) begin
      rd_x = seg_x_q[IDX_W'(rd_idx)];
      rd_y = seg_y_q[IDX_W'(rd_idx)];
    end
  end

  assign rd_valid       = (rd_idx < len_q);
  assign head_x         = seg_x_q[0];
  assign head_y         = seg_y_q[0];
  assign length         = len_q;
  assign busy           = busy_q;
  assign wall_collision = wall_q;
  assign self_collision = self_q;
  assign food_eaten     = food_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: a vector table of moves, directed corner sequences and a randomized run,
// all checked against a queue-based model of the snake body.
module tb_snake_engine;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam int ML = 64;
  localparam int IL = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] game_state;
  logic       move_enable;
  logic [1:0] dir_in;
  logic       dir_valid;
  logic [4:0] food_x, food_y;
  logic [6:0] rd_idx;
  logic [4:0] rd_x, rd_y;
  logic       rd_valid;
  logic [4:0] head_x, head_y;
  logic [6:0] length;
  logic       busy, wall_collision, self_collision, food_eaten;

  snake_engine dut (
    .clk(clk), .reset_n(reset_n), .game_state(game_state), .move_enable(move_enable),
    .dir_in(dir_in), .dir_valid(dir_valid), .food_x(food_x), .food_y(food_y),
    .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
    .head_x(head_x), .head_y(head_y), .length(length), .busy(busy),
    .wall_collision(wall_collision), .self_collision(self_collision), .food_eaten(food_eaten)
  );

  always #5 clk = ~clk;

  typedef struct {
    int wall; int self_hit; int food; int busy_cyc; int hx; int hy; int len;
  } res_t;

  typedef struct {
    bit dv; int d; int fx; int fy; res_t exp_r;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model: body as coordinate queues, head at the front.
  int mq_x[$];
  int mq_y[$];
  int m_cur, m_pend;

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_init();
    mq_x.delete();
    mq_y.delete();
    for (int i = 0; i < IL; i++) begin
      mq_x.push_back(GW / 2 - i);
      mq_y.push_back(GH / 2);
    end
    m_cur  = 1;
    m_pend = 1;
  endfunction

  function automatic int m_eff(input bit dv, input int d);
    return (dv && d != (m_cur ^ 2)) ? d : m_pend;
  endfunction

  function automatic void m_peek(input int dir, output int nx, output int ny, output bit off_grid);
    nx = mq_x[0];
    ny = mq_y[0];
    case (dir)
      0: ny = ny - 1;
      1: nx = nx + 1;
      2: ny = ny + 1;
      default: nx = nx - 1;
    endcase
    off_grid = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
  endfunction

  function automatic void m_move(input bit dv, input int d, input int fx, input int fy, output res_t r);
    int nx, ny, n;
    bit off_grid, grow;
    r = '{default: 0};
    m_pend = m_eff(dv, d);
    m_cur  = m_pend;
    m_peek(m_cur, nx, ny, off_grid);
`ifdef SNAKE_WRAP_EN
    off_grid = 1'b0;
`endif
    if (off_grid) begin
      r.wall = 1;
    end else begin
      grow = (nx == fx) && (ny == fy);
      n = grow ? mq_x.size() : mq_x.size() - 1;
      for (int k = 0; k < n; k++)
        if (mq_x[k] == nx && mq_y[k] == ny) r.self_hit = 1;
      r.busy_cyc = n + 1;
      if (r.self_hit == 0) begin
        mq_x.push_front(nx);
        mq_y.push_front(ny);
        if (!grow || mq_x.size() > ML) begin
          void'(mq_x.pop_back());
          void'(mq_y.pop_back());
        end
        r.food = grow ? 1 : 0;
      end
    end
    r.hx  = mq_x[0];
    r.hy  = mq_y[0];
    r.len = mq_x.size();
  endfunction

  function automatic vec_t mk(input bit dv, input int d, input int fx, input int fy,
                              input int w, input int s, input int f, input int b,
                              input int hx, input int hy, input int len);
    vec_t v;
    v.dv = dv; v.d = d; v.fx = fx; v.fy = fy;
    v.exp_r = '{w, s, f, b, hx, hy, len};
    return v;
  endfunction

  // One move: strobe, count busy cycles, sample pulses/head/length, then confirm pulses drop.
  task automatic run_move(input bit dv, input int d, input int fx, input int fy, input bit inject,
                          output res_t exp_r, output res_t got);
    int cnt;
    m_move(dv, d, fx, fy, exp_r);
    dir_valid   = dv;
    dir_in      = 2'(d);
    food_x      = 5'(fx);
    food_y      = 5'(fy);
    move_enable = 1'b1;
    step();
    move_enable = 1'b0;
    dir_valid   = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      move_enable = inject && (cnt == 1);
      step();
      cnt++;
    end
    move_enable  = 1'b0;
    got.busy_cyc = cnt;
    got.wall     = int'(wall_collision);
    got.self_hit = int'(self_collision);
    got.food     = int'(food_eaten);
    got.hx       = int'(head_x);
    got.hy       = int'(head_y);
    got.len      = int'(length);
    step();
    chk("pulse_clear", int'({wall_collision, self_collision, food_eaten}), 0);
  endtask

  task automatic cmp_res(input string tag, input res_t g, input res_t e);
    chk({tag, ".wall"}, g.wall, e.wall);
    chk({tag, ".self"}, g.self_hit, e.self_hit);
    chk({tag, ".food"}, g.food, e.food);
    chk({tag, ".busy_cycles"}, g.busy_cyc, e.busy_cyc);
    chk({tag, ".head_x"}, g.hx, e.hx);
    chk({tag, ".head_y"}, g.hy, e.hy);
    chk({tag, ".length"}, g.len, e.len);
  endtask

  task automatic check_body(input string tag);
    for (int i = 0; i <= mq_x.size() && i < 128; i++) begin
      rd_idx = 7'(i);
      #1;
      chk($sformatf("%s.rd_valid[%0d]", tag, i), int'(rd_valid), (i < mq_x.size()) ? 1 : 0);
      if (i < mq_x.size()) begin
        chk($sformatf("%s.rd_x[%0d]", tag, i), int'(rd_x), mq_x[i]);
        chk($sformatf("%s.rd_y[%0d]", tag, i), int'(rd_y), mq_y[i]);
      end
    end
  endtask

  task automatic reinit();
    game_state = 2'b00;
    step();
    m_init();
    game_state = 2'b01;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    res_t e, g;

    tbl[0] = mk(0, 0, 0,  0,  0, 0, 0, 3, 17, 12, 3);
    tbl[1] = mk(0, 0, 18, 12, 0, 0, 1, 4, 18, 12, 4);
    tbl[2] = mk(1, 3, 0,  0,  0, 0, 0, 4, 19, 12, 4);
    tbl[3] = mk(1, 0, 0,  0,  0, 0, 0, 4, 19, 11, 4);
    tbl[4] = mk(1, 3, 18, 11, 0, 0, 1, 5, 18, 11, 5);
    tbl[5] = mk(1, 2, 0,  0,  0, 1, 0, 5, 18, 11, 5);
    tbl[6] = mk(1, 3, 0,  0,  0, 0, 0, 5, 17, 11, 5);

    reset_n = 1'b0; game_state = 2'b00; move_enable = 1'b0;
    dir_in = 2'd0; dir_valid = 1'b0; food_x = '0; food_y = '0; rd_idx = 7'd2;
    m_init();
    step();
    step();
    chk("rst.busy", int'(busy), 0);
    chk("rst.length", int'(length), 3);
    chk("rst.head_x", int'(head_x), 16);
    chk("rst.head_y", int'(head_y), 12);
    chk("rst.pulses", int'({wall_collision, self_collision, food_eaten}), 0);
    chk("rst.rd_x2", int'(rd_x), 14);
    chk("rst.rd_valid2", int'(rd_valid), 1);
    rd_idx = 7'd3;
    #1;
    chk("rst.rd_valid3", int'(rd_valid), 0);
    reset_n = 1'b1;
    game_state = 2'b01;
    step();

    // Vector table: grow, reversal ignored, same-cycle turn, closed-loop self collision.
    for (int i = 0; i < 7; i++) begin
      run_move(tbl[i].dv, tbl[i].d, tbl[i].fx, tbl[i].fy, (i % 2) == 1, e, g);
      cmp_res($sformatf("vec%0d", i), g, tbl[i].exp_r);
    end
    rd_idx = 7'd4;
    #1;
    chk("vec.seg4_x", int'(rd_x), 18);
    chk("vec.seg4_y", int'(rd_y), 12);
    check_body("vec");

    // Drive the head to the right edge, then one more move right.
    reinit();
    for (int i = 0; i < 15; i++) begin
      run_move(0, 1, 0, 0, 0, e, g);
      cmp_res("edge_run", g, e);
    end
    chk("edge.head_x", int'(head_x), 31);
    run_move(0, 1, 0, 0, 0, e, g);
    cmp_res("wall", g, e);
`ifdef SNAKE_WRAP_EN
    chk("wrap.pulse", g.wall, 0);
    chk("wrap.head_x", g.hx, 0);
`else
    chk("wall.pulse", g.wall, 1);
    chk("wall.busy", g.busy_cyc, 0);
    chk("wall.head_x", g.hx, 31);
`endif
    check_body("wall");

    // GAME_OVER mid-scan aborts the move; body frozen, strobes ignored.
    run_move(1, 0, 0, 0, 0, e, g);
    cmp_res("turn_up", g, e);
    move_enable = 1'b1;
    step();
    move_enable = 1'b0;
    chk("abort.busy_scan", int'(busy), 1);
    game_state = 2'b10;
    step();
    chk("abort.busy_ready", int'(busy), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
        move_enable = 1'b1;
        step();
        seen = seen | int'({busy, wall_collision, self_collision, food_eaten});
      end
      move_enable = 1'b0;
      chk("abort.quiet", seen, 0);
    end
    chk("abort.head_x", int'(head_x), mq_x[0]);
    chk("abort.head_y", int'(head_y), mq_y[0]);
    chk("abort.length", int'(length), mq_x.size());
    game_state = 2'b01;

    // Serpentine with food on every next cell drives length into saturation.
    reinit();
    for (int m = 0; m < 75; m++) begin
      bit dv, og;
      int d, nx, ny;
      dv = 1'b0;
      d  = m_cur;
      if (m_cur == 1 && mq_x[0] == GW - 2) begin dv = 1'b1; d = 0; end
      else if (m_cur == 0) begin dv = 1'b1; d = (mq_x[0] >= GW - 2) ? 3 : 1; end
      else if (m_cur == 3 && mq_x[0] == 1) begin dv = 1'b1; d = 0; end
      m_peek(d, nx, ny, og);
      run_move(dv, d, nx, ny, m % 3 == 0, e, g);
      cmp_res($sformatf("grow%0d", m), g, e);
    end
    chk("sat.length", int'(length), ML);
    check_body("sat");

    // Randomized moves against the model.
    reinit();
    for (int m = 0; m < 120; m++) begin
      bit dv, og;
      int d, fx, fy, nx, ny;
      if (m > 0 && m % 40 == 0) reinit();
      dv = 1'($urandom % 2);
      d  = int'($urandom % 4);
      m_peek(m_eff(dv, d), nx, ny, og);
      if ($urandom % 2 == 1) begin
        fx = nx; fy = ny;
      end else begin
        fx = int'($urandom % GW); fy = int'($urandom % GH);
      end
      run_move(dv, d, fx, fy, ($urandom % 4) == 0, e, g);
      cmp_res($sformatf("rand%0d", m), g, e);
    end
    check_body("rand");

    // Asynchronous reset in the middle of a scan.
    reinit();
    move_enable = 1'b1;
    step();
    move_enable = 1'b0;
    chk("arst.busy_scan", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.length", int'(length), 3);
    chk("arst.head_x", int'(head_x), 16);
    chk("arst.head_y", int'(head_y), 12);
    chk("arst.pulses", int'({wall_collision, self_collision, food_eaten}), 0);
    rd_idx = 7'd1;
    #1;
    chk("arst.rd_x1", int'(rd_x), 15);
    chk("arst.rd_y1", int'(rd_y), 12);
    step();
    reset_n = 1'b1;
    m_init();
    step();
    run_move(0, 1, 0, 0, 0, e, g);
    cmp_res("post_reset", g, e);
    chk("post_reset.head_x", g.hx, 17);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
